// File: rtl/round_robin_multiplexer_pkg.sv
// Shared types and helpers for the round-robin N-to-1 packet multiplexer.
// The arbiter and the top-level FSM both import this package.
package multiplexer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } muxState;

  // Grant index width; a single source still needs one bit to carry index 0.
  function automatic int selectWidthFor(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  // Modulo increment that stays legal for counts that are not a power of two.
  function automatic int nextPointer(input int index, input int count);
    return (index + 1 >= count) ? 0 : index + 1;
  endfunction

endpackage

// File: rtl/round_robin_multiplexer_if.sv
// Valid/ready bundle between NUMBER_OF_INPUTS sources and one sink.
// master = the side driving sources and the sink's ready; slave = the multiplexer.
interface round_robin_multiplexer_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_INPUTS = 4,
  parameter int SELECT_WIDTH     = (NUMBER_OF_INPUTS > 1) ? $clog2(NUMBER_OF_INPUTS) : 1
);

  logic [NUMBER_OF_INPUTS-1:0][DATA_WIDTH-1:0] inputData;
  logic [NUMBER_OF_INPUTS-1:0]                 inputValid;
  logic [NUMBER_OF_INPUTS-1:0]                 inputLast;
  logic [NUMBER_OF_INPUTS-1:0]                 inputReady;

  logic [DATA_WIDTH-1:0]                       outputData;
  logic                                        outputValid;
  logic                                        outputLast;
  logic                                        outputReady;
  logic [SELECT_WIDTH-1:0]                     outputSelect;

  modport master (
    output inputData, inputValid, inputLast, outputReady,
    input  inputReady, outputData, outputValid, outputLast, outputSelect
  );

  modport slave (
    input  inputData, inputValid, inputLast, outputReady,
    output inputReady, outputData, outputValid, outputLast, outputSelect
  );

endinterface

// File: rtl/round_robin_multiplexer_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or above
// priorityPointer, wrapping to the lowest requester when none is found above it.
module round_robin_arbiter
  import multiplexer_pkg::*;
#(
  parameter int NUMBER_OF_INPUTS = 4,
  parameter int SELECT_WIDTH     = selectWidthFor(NUMBER_OF_INPUTS)
) (
  input  logic [NUMBER_OF_INPUTS-1:0] request,
  input  logic [SELECT_WIDTH-1:0]     priorityPointer,
  output logic [SELECT_WIDTH-1:0]     winner,
  output logic                        anyRequest
);

  logic [NUMBER_OF_INPUTS-1:0] upperRequest;
  logic [SELECT_WIDTH-1:0]     upperWinner;
  logic [SELECT_WIDTH-1:0]     lowerWinner;
  logic                        upperFound;

  // Requests at or above the pointer take precedence over the wrapped ones.
  for (genvar gi = 0; gi < NUMBER_OF_INPUTS; gi++) begin : gUpper
    assign upperRequest[gi] = request[gi] && (SELECT_WIDTH'(gi) >= priorityPointer);
  end

  always_comb begin
    upperWinner = '0;
    upperFound  = 1'b0;
    for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
      if (!upperFound && upperRequest[i]) begin
        upperWinner = SELECT_WIDTH'(i);
        upperFound  = 1'b1;
      end
    end
  end

  always_comb begin
    lowerWinner = '0;
    for (int i = NUMBER_OF_INPUTS - 1; i >= 0; i--) begin
      if (request[i]) begin
        lowerWinner = SELECT_WIDTH'(i);
      end
    end
  end

  assign anyRequest = |request;
  assign winner     = upperFound ? upperWinner : lowerWinner;

endmodule

// File: rtl/round_robin_multiplexer.sv
// N-to-1 packet multiplexer: a registered round-robin grant that holds for a
// whole packet, with a zero-latency pass-through of the granted source.
module round_robin_multiplexer
  import multiplexer_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_INPUTS = 4,
  parameter int SELECT_WIDTH     = selectWidthFor(NUMBER_OF_INPUTS)
) (
  input  logic                     clock,
  input  logic                     reset,
  round_robin_multiplexer_if.slave bus
);

  muxState                     state;
  logic [SELECT_WIDTH-1:0]     grantIndex;
  logic [SELECT_WIDTH-1:0]     priorityPointer;

  logic [SELECT_WIDTH-1:0]     winner;
  logic                        anyRequest;

  logic [DATA_WIDTH-1:0]       selectedData;
  logic                        selectedValid;
  logic                        selectedLast;
  logic [NUMBER_OF_INPUTS-1:0] readyVector;
  logic                        packetDone;

  round_robin_arbiter #(
    .NUMBER_OF_INPUTS (NUMBER_OF_INPUTS),
    .SELECT_WIDTH     (SELECT_WIDTH)
  ) arbiter (
    .request         (bus.inputValid),
    .priorityPointer (priorityPointer),
    .winner          (winner),
    .anyRequest      (anyRequest)
  );

  // Everything downstream sees is gated by BUSY, so IDLE drives zeros.
  always_comb begin
    selectedData  = '0;
    selectedValid = 1'b0;
    selectedLast  = 1'b0;
    readyVector   = '0;
    if (state == BUSY) begin
      for (int i = 0; i < NUMBER_OF_INPUTS; i++) begin
        if (grantIndex == SELECT_WIDTH'(i)) begin
          selectedData   = bus.inputData[i];
          selectedValid  = bus.inputValid[i];
          selectedLast   = bus.inputLast[i];
          readyVector[i] = bus.outputReady;
        end
      end
    end
  end

  assign packetDone = selectedValid && bus.outputReady && selectedLast;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      grantIndex      <= '0;
      priorityPointer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (anyRequest) begin
            grantIndex <= winner;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Only an accepted last beat releases the grant; a stalled or
          // dropped beat keeps the packet locked to this source.
          if (packetDone) begin
            state           <= IDLE;
            priorityPointer <= SELECT_WIDTH'(nextPointer(int'(grantIndex), NUMBER_OF_INPUTS));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.outputData   = selectedData;
  assign bus.outputValid  = selectedValid;
  assign bus.outputLast   = selectedLast;
  assign bus.inputReady   = readyVector;
  assign bus.outputSelect = grantIndex;

  pointerInRange: assert property (@(posedge clock) disable iff (!reset)
    int'(priorityPointer) < NUMBER_OF_INPUTS);

  grantInRange: assert property (@(posedge clock) disable iff (!reset)
    int'(grantIndex) < NUMBER_OF_INPUTS);

  readyOnlyToGrant: assert property (@(posedge clock) disable iff (!reset)
    $onehot0(readyVector));

endmodule

// File: tb/tb_round_robin_multiplexer.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbitration rules.
module tb_round_robin_multiplexer;

  logic clock;
  logic reset;

  int testsRun    = 0;
  int testsFailed = 0;

  round_robin_multiplexer_if #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(4)) bus4 ();
  round_robin_multiplexer_if #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(3)) bus3 ();

  round_robin_multiplexer #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  round_robin_multiplexer #(.DATA_WIDTH(32), .NUMBER_OF_INPUTS(3)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bus3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Behavioural model of the 4-input instance: packet ownership and pointer.
  int          mBusy;
  int          mGrant;
  int          mPtr;
  logic [31:0] eData;
  logic        eValid;
  logic        eLast;
  logic [3:0]  eReady;
  logic [1:0]  eSelect;

  task automatic modelReset();
    mBusy  = 0;
    mGrant = 0;
    mPtr   = 0;
  endtask

  task automatic predict();
    logic [1:0] g;
    g       = mGrant[1:0];
    eData   = '0;
    eValid  = 1'b0;
    eLast   = 1'b0;
    eReady  = '0;
    eSelect = g;
    if (mBusy != 0) begin
      eData     = bus4.inputData[g];
      eValid    = bus4.inputValid[g];
      eLast     = bus4.inputLast[g];
      eReady[g] = bus4.outputReady;
    end
  endtask

  task automatic advance();
    int found;
    logic [1:0] idx;
    if (mBusy == 0) begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        idx = 2'((mPtr + k) % 4);
        if (found == 0 && bus4.inputValid[idx]) begin
          found  = 1;
          mGrant = int'(idx);
          mBusy  = 1;
        end
      end
    end else if (eValid && bus4.outputReady && eLast) begin
      mBusy = 0;
      mPtr  = (mGrant + 1) % 4;
    end
  endtask

  function automatic logic [39:0] observed4();
    return {bus4.outputValid, bus4.outputLast, bus4.outputSelect, bus4.inputReady, bus4.outputData};
  endfunction

  function automatic logic [39:0] expected4();
    return {eValid, eLast, eSelect, eReady, eData};
  endfunction

  task automatic clearInputs();
    bus4.inputData   = '0;
    bus4.inputValid  = '0;
    bus4.inputLast   = '0;
    bus4.outputReady = 1'b0;
    bus3.inputData   = '0;
    bus3.inputValid  = '0;
    bus3.inputLast   = '0;
    bus3.outputReady = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic doReset();
    @(negedge clock);
    reset = 1'b0;
    clearInputs();
    modelReset();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset            = 1'b0;
    bus4.inputValid  = 4'hF;
    bus4.inputLast   = 4'hF;
    bus4.outputReady = 1'b1;
    for (int i = 0; i < 4; i++) bus4.inputData[i] = $urandom;
    for (int c = 0; c < 3; c++) begin
      #1;
      testsRun++;
      if (observed4() !== 40'h0) begin
        testsFailed++;
        $display("FAIL reset_outputs cycle %0d: got %h, required 0", c, observed4());
      end
      @(negedge clock);
    end
    reset = 1'b1;
    modelReset();
    for (int c = 0; c < 2; c++) begin
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL reset_release_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      testsRun++;
      if (bus4.outputValid !== (c == 1) || (c == 1 && bus4.outputSelect !== 2'd0)) begin
        testsFailed++;
        $display("FAIL reset_first_grant cycle %0d: got valid=%b select=%0d, required valid=%b select=0",
                 c, bus4.outputValid, bus4.outputSelect, (c == 1));
      end
      advance();
      @(negedge clock);
    end
  endtask

  task automatic test_fairness();
    doReset();
    bus4.inputValid  = 4'hF;
    bus4.inputLast   = 4'hF;
    bus4.outputReady = 1'b1;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < 4; i++) bus4.inputData[i] = $urandom;
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL fairness_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      testsRun++;
      if (bus4.outputValid !== (c % 2 == 1) ||
          (c % 2 == 1 && bus4.outputSelect !== 2'((c / 2) % 4))) begin
        testsFailed++;
        $display("FAIL fairness_sequence cycle %0d: got valid=%b select=%0d, required valid=%b select=%0d",
                 c, bus4.outputValid, bus4.outputSelect, (c % 2 == 1), (c / 2) % 4);
      end
      advance();
      @(negedge clock);
    end
  endtask

  task automatic test_multi_beat_lock();
    logic [31:0] beats [3];
    beats[0] = 32'hA;
    beats[1] = 32'hB;
    beats[2] = 32'hC;
    doReset();
    bus4.outputReady  = 1'b1;
    bus4.inputData[1] = 32'h11;
    bus4.inputLast[1] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus4.inputValid[1] = 1'b1;
      bus4.inputValid[2] = (c >= 2 && c <= 5);
      bus4.inputData[2]  = (c <= 3) ? beats[0] : (c == 4) ? beats[1] : beats[2];
      bus4.inputLast[2]  = (c == 5);
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL lock_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      if (c >= 3 && c <= 5) begin
        testsRun++;
        if (bus4.outputData !== beats[c-3] || bus4.inputReady[1] !== 1'b0 || bus4.outputSelect !== 2'd2) begin
          testsFailed++;
          $display("FAIL lock_beat cycle %0d: got data=%h ready1=%b select=%0d, required data=%h ready1=0 select=2",
                   c, bus4.outputData, bus4.inputReady[1], bus4.outputSelect, beats[c-3]);
        end
      end
      if (c == 7) begin
        testsRun++;
        if (bus4.outputValid !== 1'b1 || bus4.outputSelect !== 2'd1) begin
          testsFailed++;
          $display("FAIL lock_next_grant: got valid=%b select=%0d, required valid=1 select=1",
                   bus4.outputValid, bus4.outputSelect);
        end
      end
      advance();
      @(negedge clock);
    end
  endtask

  task automatic test_backpressure();
    int b = 0;
    doReset();
    bus4.inputValid[3] = 1'b1;
    bus4.inputLast[3]  = 1'b1;
    bus4.inputData[3]  = 32'h333;
    for (int c = 0; c < 12; c++) begin
      bus4.outputReady   = !(c >= 2 && c <= 6);
      bus4.inputValid[0] = (b < 4);
      bus4.inputData[0]  = 32'h100 + 32'(b);
      bus4.inputLast[0]  = (b == 3);
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL backpressure_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      if (c >= 2 && c <= 6) begin
        testsRun++;
        if (bus4.outputData !== 32'h101 || bus4.inputReady !== 4'h0 || bus4.outputSelect !== 2'd0) begin
          testsFailed++;
          $display("FAIL backpressure_hold cycle %0d: got data=%h ready=%b select=%0d, required data=101 ready=0000 select=0",
                   c, bus4.outputData, bus4.inputReady, bus4.outputSelect);
        end
      end
      if (c == 11) begin
        testsRun++;
        if (bus4.outputValid !== 1'b1 || bus4.outputSelect !== 2'd3) begin
          testsFailed++;
          $display("FAIL backpressure_next_grant: got valid=%b select=%0d, required valid=1 select=3",
                   bus4.outputValid, bus4.outputSelect);
        end
      end
      if (bus4.inputValid[0] && bus4.inputReady[0]) b++;
      advance();
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_packet();
    int b = 0;
    doReset();
    bus4.outputReady = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus4.inputValid[3] = 1'b1;
      bus4.inputData[3]  = 32'h300 + 32'(b);
      bus4.inputLast[3]  = (b == 3);
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL midreset_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      if (bus4.inputValid[3] && bus4.inputReady[3]) b++;
      if (c < 3) begin
        advance();
        @(negedge clock);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    testsRun++;
    if (bus4.outputValid !== 1'b0 || bus4.inputReady !== 4'h0 || bus4.outputSelect !== 2'd0) begin
      testsFailed++;
      $display("FAIL midreset_async: got valid=%b ready=%b select=%0d, required valid=0 ready=0000 select=0",
               bus4.outputValid, bus4.inputReady, bus4.outputSelect);
    end
    modelReset();
    @(negedge clock);
    reset = 1'b1;
    bus4.inputValid   = 4'b1010;
    bus4.inputLast    = 4'b1010;
    bus4.inputData[1] = 32'h111;
    for (int c = 0; c < 2; c++) begin
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL midreset_restart_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      if (c == 1) begin
        testsRun++;
        if (bus4.outputValid !== 1'b1 || bus4.outputSelect !== 2'd1) begin
          testsFailed++;
          $display("FAIL midreset_restart_grant: got valid=%b select=%0d, required valid=1 select=1",
                   bus4.outputValid, bus4.outputSelect);
        end
      end
      advance();
      @(negedge clock);
    end
  endtask

  task automatic test_wrap_three_inputs();
    logic [2:0] validSeq [4];
    logic [1:0] grantSeq [4];
    validSeq[0] = 3'b010; grantSeq[0] = 2'd1;
    validSeq[1] = 3'b010; grantSeq[1] = 2'd1;
    validSeq[2] = 3'b100; grantSeq[2] = 2'd2;
    validSeq[3] = 3'b111; grantSeq[3] = 2'd0;
    doReset();
    bus3.outputReady = 1'b1;
    bus3.inputLast   = 3'b111;
    for (int p = 0; p < 4; p++) begin
      bus3.inputValid = validSeq[p];
      for (int i = 0; i < 3; i++) bus3.inputData[i] = $urandom;
      #1;
      testsRun++;
      if (bus3.outputValid !== 1'b0) begin
        testsFailed++;
        $display("FAIL wrap3_idle packet %0d: got valid=%b, required valid=0", p, bus3.outputValid);
      end
      @(negedge clock);
      #1;
      testsRun++;
      if (bus3.outputValid !== 1'b1 || bus3.outputSelect !== grantSeq[p] ||
          bus3.outputData !== bus3.inputData[grantSeq[p]]) begin
        testsFailed++;
        $display("FAIL wrap3_grant packet %0d: got valid=%b select=%0d data=%h, required valid=1 select=%0d data=%h",
                 p, bus3.outputValid, bus3.outputSelect, bus3.outputData, grantSeq[p], bus3.inputData[grantSeq[p]]);
      end
      @(negedge clock);
    end
    bus3.inputValid = '0;
  endtask

  task automatic test_random();
    doReset();
    for (int c = 0; c < 400; c++) begin
      bus4.inputValid  = 4'($urandom_range(0, 15));
      for (int i = 0; i < 4; i++) begin
        bus4.inputData[i] = $urandom;
        bus4.inputLast[i] = ($urandom_range(0, 2) == 0);
      end
      bus4.outputReady = ($urandom_range(0, 3) != 0);
      #1;
      predict();
      testsRun++;
      if (observed4() !== expected4()) begin
        testsFailed++;
        $display("FAIL random_model cycle %0d: got %h, required %h", c, observed4(), expected4());
      end
      advance();
      @(negedge clock);
    end
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    modelReset();
    test_reset();
    test_fairness();
    test_multi_beat_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_wrap_three_inputs();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/round_robin_multiplexer.md
Name: round_robin_multiplexer

Overview:
- N-to-1 arbitrated multiplexer: the gathering counterpart of the one-to-many demultiplexer.
- Collects packets from NUMBER_OF_INPUTS valid/ready sources onto a single valid/ready output.
- Arbitration is round-robin, and a grant holds for a whole packet (until a beat with last=1 is accepted).
- Sits in front of shared bus/cache ports, where several requesters contend for one channel.

Parameters:
- DATA_WIDTH, 32, width of the data payload per beat.
- NUMBER_OF_INPUTS, 4, number of source ports; any value >= 1, need not be a power of two.
- SELECT_WIDTH, max(1, $clog2(NUMBER_OF_INPUTS)), width of the grant index.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted at 0, released synchronously by the integrator.
- inputData  input  DATA_WIDTH x NUMBER_OF_INPUTS  per-source payload.
- inputValid  input  NUMBER_OF_INPUTS  per-source beat valid.
- inputLast  input  NUMBER_OF_INPUTS  per-source end-of-packet marker.
- inputReady  output  NUMBER_OF_INPUTS  per-source beat accepted when valid & ready.
- outputData  output  DATA_WIDTH  selected payload.
- outputValid  output  1  selected beat valid.
- outputLast  output  1  selected end-of-packet marker.
- outputReady  input  1  downstream acceptance.
- outputSelect  output  SELECT_WIDTH  index of the currently granted source.

Behaviour:
- States: IDLE, BUSY. Registers: state, grantIndex, priorityPointer.
- Reset (reset=0, asynchronous): state=IDLE, grantIndex=0, priorityPointer=0.
- Reset outputs: outputValid=0, outputLast=0, outputData=0, inputReady=all 0, outputSelect=0.
- IDLE arbitration:
  - Winner = first i with inputValid[i]=1, scanning from priorityPointer upward and wrapping from NUMBER_OF_INPUTS-1 to 0.
  - If any valid: grantIndex<=winner, state<=BUSY. Otherwise stay IDLE.
  - While IDLE: outputValid=0, all inputReady=0, outputData=0, outputSelect=grantIndex.
- BUSY pass-through (combinational from grantIndex):
  - outputData=inputData[grantIndex], outputValid=inputValid[grantIndex], outputLast=inputLast[grantIndex].
  - inputReady[grantIndex]=outputReady; all other inputReady=0.
  - outputSelect=grantIndex.
- Packet end: on a BUSY handshake (outputValid & outputReady) with outputLast=1, state<=IDLE and priorityPointer<=(grantIndex+1) mod NUMBER_OF_INPUTS.
- Non-last handshakes keep BUSY and the same grant.
- Latency: 1 cycle from inputValid rising in IDLE to outputValid. One mandatory idle cycle between consecutive packets (no back-to-back re-arbitration).
- Data path adds zero cycles in BUSY; throughput is 1 beat/cycle within a packet.
- Granted source drops valid mid-packet: grant held, outputValid=0 that cycle, no re-arbitration until last is accepted.
- Non-granted sources changing valid during BUSY: no effect.
- Wrap-around: grantIndex=NUMBER_OF_INPUTS-1 finishing gives pointer=0; pointer never exceeds NUMBER_OF_INPUTS-1.
- NUMBER_OF_INPUTS=1: pointer stays 0 and behaviour degenerates to a registered-grant pass-through.
- Reset mid-packet: immediate return to IDLE with all ready/valid outputs low. The partial packet is dropped; sources re-present it.
- outputReady high in IDLE: ignored.

Decomposition:
- Package multiplexer_pkg holds:
  - the state enum (IDLE, BUSY);
  - the function nextPointer(index, count) for modulo increment.
- Sub-module round_robin_arbiter: purely combinational.
  - Inputs: request vector, priorityPointer.
  - Outputs: winner index, anyRequest.
  - Reusable by other arbitrated blocks.
- The top module holds the FSM, the registers and the pass-through mux.

Test Plan:
- Reset then idle (N=4): reset=0 for 3 cycles with inputValid=4'b1111 -> all outputs 0; after release, first grant is index 0, with outputValid=1 on the second edge.
- Round-robin fairness: all four valid continuously, single-beat packets (last=1), outputReady=1 -> outputSelect sequence 0,1,2,3,0 with one IDLE cycle between each.
- Multi-beat lock: source 2 sends 3 beats (0xA,0xB,0xC; last on 0xC) while source 1 is valid -> outputData A,B,C uninterrupted, inputReady[1]=0 throughout, then source 1 granted.
- Backpressure: outputReady=0 for 5 cycles mid-packet -> outputData stable, inputReady[grant]=0, no grant change; transfer resumes when ready returns.
- Wrap and skip (N=3): pointer=2, only source 1 valid -> winner 1 and pointer becomes 2; then source 2 valid -> granted; then pointer wraps to 0.
- Reset mid-packet: assert reset after beat 2 of 4 from source 3 -> outputValid=0 and inputReady=0 asynchronously; after release, arbitration restarts from pointer 0.
